// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline controller for the five-stage core.
//
// Turns per-stage stall requests into the 6-bit stall vector used by
// pc_reg, if_id, id_ex, ex_mem and mem_wb. Raises flush/new_pc on
// exceptions and ERET. After a flush taken while the instruction bus is
// busy, a DRAIN state holds fetch until that stale transaction completes.
// Also counts stalled cycles and flags pipelines that stay stuck in stall.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stallreq_from_if/id/ex/mem per-stage stall requests
//   excepttype_i              exception code from mem stage, 0 = none
//   cp0_epc_i                 forwarded EPC, used as the ERET target
//   ibus_busy_i               instruction Wishbone transaction outstanding
//   stall                     bit0 pc .. bit5 wb, 1 = hold that stage
//   flush                     clear all pipeline registers this cycle
//   new_pc                    pc load target, valid while flush = 1
//   stall_timeout_o           registered stuck-stall flag
//   stall_cycles_o            registered count of stalled cycles (wraps)
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0040,
  parameter logic [31:0] INT_VECTOR     = 32'h0000_0020,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        ibus_busy_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout_o,
  output logic [31:0] stall_cycles_o
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [15:0] run_cnt_q, run_cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic        stall_timeout_q, stall_timeout_d;

  logic [5:0]  late_mask;   // encode of id/ex/mem requests only
  logic [5:0]  run_mask;    // full priority encode including if
  logic [31:0] exc_pc;

  always_comb begin
    // Highest requesting stage wins; everything upstream of it stops too.
    if (stallreq_from_mem)      late_mask = 6'b011111;
    else if (stallreq_from_ex)  late_mask = 6'b001111;
    else if (stallreq_from_id)  late_mask = 6'b000111;
    else                        late_mask = 6'b000000;

    // An if request stops pc and if_id so a bubble enters id.
    if (late_mask != 6'b000000) run_mask = late_mask;
    else if (stallreq_from_if)  run_mask = 6'b000011;
    else                        run_mask = 6'b000000;

    case (excepttype_i)
      32'h0000_0001:                 exc_pc = INT_VECTOR;
      32'h0000_000e:                 exc_pc = cp0_epc_i;    // ERET
      32'h0000_0008, 32'h0000_000a,
      32'h0000_000c, 32'h0000_000d:  exc_pc = EXC_VECTOR;
      default:                       exc_pc = EXC_VECTOR;
    endcase

    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (!rst) begin
      if (excepttype_i != 32'h0) begin
        // Exceptions override every stall request, in RUN and DRAIN alike.
        flush  = 1'b1;
        new_pc = exc_pc;
      end else if (state_q == DRAIN) begin
        // Fetch is held while the stale ibus transaction finishes.
        stall = 6'b000011 | late_mask;
      end else begin
        stall = run_mask;
      end
    end

    // Any flush, or staying in DRAIN, tracks the bus: busy keeps us draining.
    state_d = state_q;
    if (flush || state_q == DRAIN) state_d = ibus_busy_i ? DRAIN : RUN;

    if (stall == 6'b000000 || flush) run_cnt_d = 16'h0;
    else if (run_cnt_q == 16'hFFFF)  run_cnt_d = run_cnt_q;
    else                             run_cnt_d = run_cnt_q + 16'h1;

    stall_cycles_d  = stall_cycles_q + {31'h0, (stall != 6'b000000)};
    stall_timeout_d = (32'(run_cnt_d) >= TIMEOUT_CYCLES);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      run_cnt_q       <= 16'h0;
      stall_cycles_q  <= 32'h0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      run_cnt_q       <= run_cnt_d;
      stall_cycles_q  <= stall_cycles_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign stall_cycles_o  = stall_cycles_q;
  assign stall_timeout_o = stall_timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: table of directed vectors, hand-written
// multi-cycle sequences (drain, timeout, reset mid-drain) and randomized
// traffic, all checked against a behavioural model of the controller.
module tb_pipe_ctrl;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        r_if, r_id, r_ex, r_mem;
  logic [31:0] exc, epc;
  logic        busy;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout_o;
  logic [31:0] stall_cycles_o;

  pipe_ctrl #(
    .EXC_VECTOR    (32'h0000_0040),
    .INT_VECTOR    (32'h0000_0020),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_if (r_if),
    .stallreq_from_id (r_id),
    .stallreq_from_ex (r_ex),
    .stallreq_from_mem(r_mem),
    .excepttype_i     (exc),
    .cp0_epc_i        (epc),
    .ibus_busy_i      (busy),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .stall_timeout_o  (stall_timeout_o),
    .stall_cycles_o   (stall_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model state.
  bit          m_drain;
  logic [31:0] m_total;
  int          m_run;
  bit          m_to;

  // Combinational values observed in the most recent cycle.
  logic [5:0]  obs_stall;
  logic        obs_flush;
  logic [31:0] obs_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stall mask: everything up to and including the deepest requesting stage,
  // plus the pc. req[0]=if .. req[3]=mem.
  function automatic logic [5:0] ref_mask(input logic [3:0] req);
    int top = -1;
    for (int i = 0; i < 4; i++) if (req[i]) top = i;
    if (top < 0) return 6'b0;
    return 6'((1 << (top + 2)) - 1);
  endfunction

  function automatic logic [31:0] ref_pc(input logic [31:0] code, input logic [31:0] e);
    if (code == 32'h1) return 32'h20;
    if (code == 32'he) return e;
    return 32'h40;
  endfunction

  // One clock cycle with the currently driven inputs; checks outputs vs model.
  task automatic cycle();
    logic [3:0]  req;
    logic [5:0]  es;
    logic        ef;
    logic [31:0] ep;
    req = {r_mem, r_ex, r_id, r_if};
    es = 6'b0; ef = 1'b0; ep = 32'h0;
    if (!rst) begin
      if (exc != 0) begin
        ef = 1'b1;
        ep = ref_pc(exc, epc);
      end else if (m_drain) begin
        es = 6'b000011 | ref_mask({req[3:1], 1'b0});
      end else begin
        es = ref_mask(req);
      end
    end
    #1;
    obs_stall = stall; obs_flush = flush; obs_pc = new_pc;
    chk("stall", 32'(stall), 32'(es));
    chk("flush", 32'(flush), 32'(ef));
    chk("new_pc", new_pc, ep);
    @(posedge clk);
    if (rst) begin
      m_drain = 0; m_total = 0; m_run = 0; m_to = 0;
    end else begin
      m_drain = (ef || m_drain) && busy;
      if (es != 0) m_total = m_total + 1;
      m_run = (es != 0 && !ef) ? ((m_run < 65535) ? m_run + 1 : 65535) : 0;
      m_to = (m_run >= TO);
    end
    #1;
    chk("stall_cycles_o", stall_cycles_o, m_total);
    chk("stall_timeout_o", 32'(stall_timeout_o), 32'(m_to));
  endtask

  task automatic drive(input logic [3:0] req, input logic [31:0] code, input logic b);
    {r_mem, r_ex, r_id, r_if} = req;
    exc = code;
    busy = b;
  endtask

  typedef struct {
    logic [3:0]  req;     // {mem, ex, id, if}
    logic [31:0] code;
    logic [31:0] epc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[14];
  logic [31:0] base_cnt;

  initial begin
    // Priority staircase, then exceptions (all with ibus idle so RUN holds).
    tbl[0]  = '{4'b1111, 32'h0,  32'h0,         6'b011111, 1'b0, 32'h0};
    tbl[1]  = '{4'b0111, 32'h0,  32'h0,         6'b001111, 1'b0, 32'h0};
    tbl[2]  = '{4'b0011, 32'h0,  32'h0,         6'b000111, 1'b0, 32'h0};
    tbl[3]  = '{4'b0001, 32'h0,  32'h0,         6'b000011, 1'b0, 32'h0};
    tbl[4]  = '{4'b0000, 32'h0,  32'h0,         6'b000000, 1'b0, 32'h0};
    tbl[5]  = '{4'b1000, 32'h8,  32'h0,         6'b000000, 1'b1, 32'h40};
    tbl[6]  = '{4'b0000, 32'he,  32'hBFC0_0104, 6'b000000, 1'b1, 32'hBFC0_0104};
    tbl[7]  = '{4'b0000, 32'h1,  32'h1234_5678, 6'b000000, 1'b1, 32'h20};
    tbl[8]  = '{4'b0100, 32'ha,  32'h0,         6'b000000, 1'b1, 32'h40};
    tbl[9]  = '{4'b0010, 32'hd,  32'h0,         6'b000000, 1'b1, 32'h40};
    tbl[10] = '{4'b0001, 32'hc,  32'h0,         6'b000000, 1'b1, 32'h40};
    tbl[11] = '{4'b0000, 32'h1f, 32'h0,         6'b000000, 1'b1, 32'h40};
    tbl[12] = '{4'b0100, 32'h0,  32'h0,         6'b001111, 1'b0, 32'h0};
    tbl[13] = '{4'b0010, 32'h0,  32'h0,         6'b000111, 1'b0, 32'h0};

    m_drain = 0; m_total = 0; m_run = 0; m_to = 0;
    rst = 1'b1; epc = 32'h0;
    drive(4'b1111, 32'h0, 1'b1);
    @(posedge clk); #1;
    cycle();                     // reset: outputs forced to 0
    cycle();
    rst = 1'b0;
    chk("reset_cycles", stall_cycles_o, 32'h0);
    chk("reset_timeout", 32'(stall_timeout_o), 32'h0);

    base_cnt = stall_cycles_o;
    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].code, 1'b0);
      epc = tbl[i].epc;
      cycle();
      $display("vec %0d req=%b exc=%h stall=%b flush=%b new_pc=%h", i, tbl[i].req,
               tbl[i].code, obs_stall, obs_flush, obs_pc);
      chk("tbl_stall", 32'(obs_stall), 32'(tbl[i].e_stall));
      chk("tbl_flush", 32'(obs_flush), 32'(tbl[i].e_flush));
      chk("tbl_new_pc", obs_pc, tbl[i].e_pc);
      if (i == 4) chk("staircase_count", stall_cycles_o - base_cnt, 32'd4);
    end

    // Run counter cleared by an exception: 3 stalls, flush, 3 stalls -> no timeout.
    for (int k = 0; k < 3; k++) begin drive(4'b0100, 32'h0, 1'b0); cycle(); end
    drive(4'b1000, 32'h8, 1'b0); cycle();
    for (int k = 0; k < 3; k++) begin
      drive(4'b0100, 32'h0, 1'b0); cycle();
      chk("run_cleared_timeout", 32'(stall_timeout_o), 32'h0);
    end
    drive(4'b0000, 32'h0, 1'b0); cycle();

    // Drain: flush with ibus busy, then 3 busy cycles, then bus goes idle.
    drive(4'b0000, 32'h8, 1'b1); cycle();
    for (int k = 0; k < 3; k++) begin
      drive(4'b0000, 32'h0, 1'b1); cycle();
      $display("drain %0d stall=%b", k, obs_stall);
      chk("drain_stall", 32'(obs_stall), 32'h3);
    end
    drive(4'b0000, 32'h0, 1'b0); cycle();
    drive(4'b0000, 32'h0, 1'b0); cycle();
    chk("after_drain_stall", 32'(obs_stall), 32'h0);
    // Flush with idle bus must not drain.
    drive(4'b0000, 32'h8, 1'b0); cycle();
    drive(4'b0000, 32'h0, 1'b1); cycle();
    chk("no_drain_stall", 32'(obs_stall), 32'h0);

    // Timeout: ex held 6 cycles, flag rises on the 4th edge.
    for (int k = 1; k <= 6; k++) begin
      drive(4'b0100, 32'h0, 1'b0); cycle();
      $display("timeout %0d flag=%b", k, stall_timeout_o);
      chk("timeout_flag", 32'(stall_timeout_o), (k >= TO) ? 32'h1 : 32'h0);
    end
    drive(4'b0000, 32'h0, 1'b0); cycle();
    chk("timeout_fall", 32'(stall_timeout_o), 32'h0);

    // Reset mid-DRAIN with a request active.
    drive(4'b0000, 32'h8, 1'b1); cycle();
    drive(4'b0100, 32'h0, 1'b1); cycle();
    rst = 1'b1; cycle();
    rst = 1'b0;
    chk("rst_cycles", stall_cycles_o, 32'h0);
    chk("rst_timeout", 32'(stall_timeout_o), 32'h0);
    drive(4'b0000, 32'h0, 1'b1); cycle();
    chk("rst_run_stall", 32'(obs_stall), 32'h0);
    drive(4'b0010, 32'h0, 1'b1); cycle();
    chk("rst_run_id", 32'(obs_stall), 32'h7);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] codes[7];
      codes = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, $urandom_range(2, 255)};
      r_if  = ($urandom_range(0, 2) == 0);
      r_id  = ($urandom_range(0, 3) == 0);
      r_ex  = ($urandom_range(0, 3) == 0);
      r_mem = ($urandom_range(0, 4) == 0);
      exc   = ($urandom_range(0, 7) == 0) ? codes[$urandom_range(0, 6)] : 32'h0;
      epc   = $urandom;
      busy  = $urandom_range(0, 1) == 1;
      rst   = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
